// File: rtl/axi4_stream_packet_arbiter.sv
// Two-source AXI4-Stream arbiter with round-robin grant held for a whole packet; registered output, one idle cycle per grant.
// Sources see TREADY only while granted and the output register is free; downstream TREADY low stalls the granted source.
module axi4_stream_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESET,
    input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
    input  logic                  S0_AXIS_TVALID,
    input  logic                  S0_AXIS_TLAST,
    output logic                  S0_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
    input  logic                  S1_AXIS_TVALID,
    input  logic                  S1_AXIS_TLAST,
    output logic                  S1_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  SEL_ID,
    output logic [CNT_WIDTH-1:0]  PKT_COUNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  sel_q, sel_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic out_free;
    logic s0_rdy;
    logic s1_rdy;
    logic s0_hs;
    logic s1_hs;

    // The output register can take a new beat when empty or when its beat leaves this cycle.
    assign out_free = !m_tvalid_q || M_AXIS_TREADY;
    assign s0_rdy   = (state_q == GRANT0) && out_free;
    assign s1_rdy   = (state_q == GRANT1) && out_free;
    assign s0_hs    = S0_AXIS_TVALID && s0_rdy;
    assign s1_hs    = S1_AXIS_TVALID && s1_rdy;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (S0_AXIS_TVALID) begin
                    state_d = GRANT0;
                end else if (S1_AXIS_TVALID) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (s0_hs && S0_AXIS_TLAST) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GRANT1: begin
                if (s1_hs && S1_AXIS_TLAST) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        sel_d      = sel_q;
        if (s0_hs) begin
            m_tdata_d  = S0_AXIS_TDATA;
            m_tlast_d  = S0_AXIS_TLAST;
            sel_d      = 1'b0;
            m_tvalid_d = 1'b1;
        end else if (s1_hs) begin
            m_tdata_d  = S1_AXIS_TDATA;
            m_tlast_d  = S1_AXIS_TLAST;
            sel_d      = 1'b1;
            m_tvalid_d = 1'b1;
        end else if (M_AXIS_TREADY) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (m_tvalid_q && M_AXIS_TREADY && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            sel_q        <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            sel_q        <= sel_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign S0_AXIS_TREADY = s0_rdy;
    assign S1_AXIS_TREADY = s1_rdy;
    assign M_AXIS_TDATA   = m_tdata_q;
    assign M_AXIS_TVALID  = m_tvalid_q;
    assign M_AXIS_TLAST   = m_tlast_q;
    assign SEL_ID         = sel_q;
    assign PKT_COUNT      = pkt_cnt_q;

endmodule

// File: tb/tb_axi4_stream_packet_arbiter.sv
// Bench for axi4_stream_packet_arbiter: cycle vector table, hand sequences and randomized traffic against a packet scoreboard.
module tb_axi4_stream_packet_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] s0_d, s1_d, m_d, m_d_w;
    logic          s0_v, s0_l, s0_r, s1_v, s1_l, s1_r;
    logic          m_v, m_l, m_r, sel;
    logic [15:0]   cnt;
    logic          s0_r_w, s1_r_w, m_v_w, m_l_w, sel_w;
    logic [3:0]    cnt_w;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_cnt = 0;

    axi4_stream_packet_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TDATA(s0_d), .S0_AXIS_TVALID(s0_v), .S0_AXIS_TLAST(s0_l), .S0_AXIS_TREADY(s0_r),
        .S1_AXIS_TDATA(s1_d), .S1_AXIS_TVALID(s1_v), .S1_AXIS_TLAST(s1_l), .S1_AXIS_TREADY(s1_r),
        .M_AXIS_TDATA(m_d), .M_AXIS_TVALID(m_v), .M_AXIS_TLAST(m_l), .M_AXIS_TREADY(m_r),
        .SEL_ID(sel), .PKT_COUNT(cnt)
    );

    axi4_stream_packet_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w4 (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TDATA(s0_d), .S0_AXIS_TVALID(s0_v), .S0_AXIS_TLAST(s0_l), .S0_AXIS_TREADY(s0_r_w),
        .S1_AXIS_TDATA(s1_d), .S1_AXIS_TVALID(s1_v), .S1_AXIS_TLAST(s1_l), .S1_AXIS_TREADY(s1_r_w),
        .M_AXIS_TDATA(m_d_w), .M_AXIS_TVALID(m_v_w), .M_AXIS_TLAST(m_l_w), .M_AXIS_TREADY(m_r),
        .SEL_ID(sel_w), .PKT_COUNT(cnt_w)
    );

    typedef struct {
        logic          rst;
        logic          s0v;
        logic [DW-1:0] s0d;
        logic          s0l;
        logic          s1v;
        logic [DW-1:0] s1d;
        logic          s1l;
        logic          mr;
        logic          e_s0r;
        logic          e_s1r;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          e_ml;
        logic          e_sel;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int r, int a_v, int a_d, int a_l, int b_v, int b_d, int b_l, int rdy,
                                int e0, int e1, int emv, int emd, int eml, int esel, int ecnt);
        vec_t v;
        v.rst = 1'(r);     v.s0v = 1'(a_v);  v.s0d = 32'(a_d);  v.s0l = 1'(a_l);
        v.s1v = 1'(b_v);   v.s1d = 32'(b_d); v.s1l = 1'(b_l);   v.mr  = 1'(rdy);
        v.e_s0r = 1'(e0);  v.e_s1r = 1'(e1); v.e_mv = 1'(emv);  v.e_md = 32'(emd);
        v.e_ml = 1'(eml);  v.e_sel = 1'(esel); v.e_cnt = 16'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int r, input int a_v, input int a_d, input int a_l,
                          input int b_v, input int b_d, input int b_l, input int rdy);
        rst  = 1'(r);
        s0_v = 1'(a_v); s0_d = 32'(a_d); s0_l = 1'(a_l);
        s1_v = 1'(b_v); s1_d = 32'(b_d); s1_l = 1'(b_l);
        m_r  = 1'(rdy);
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = 0;
        chk("reset_out", 64'({m_v, m_l, sel, m_d}), 64'(0));
        chk("reset_cnt", 64'(cnt), 64'(0));
        chk("reset_cnt_w4", 64'(cnt_w), 64'(0));
    endtask

    // Scoreboard run: each source owns a list of packets; every M handshake must pop the
    // head of its SEL_ID source queue, packets must not interleave, and the count tracks TLAST handshakes.
    task automatic run_traffic(input int npk, input int maxlen, input int pv, input int pr,
                               input bit first16, input int stop_pkts, input bit alt);
        logic [DW-1:0] d0[$], d1[$], q0d[$], q1d[$];
        logic          l0[$], l1[$], q0l[$], q1l[$];
        int   idx0 = 0, idx1 = 0, pkts = 0, cyc = 0;
        bit   v0 = 0, v1 = 0, hs0, hs1, in_pkt = 0, cur = 0, next_alt = 0;
        logic          prev_v = 1'b0, prev_r = 1'b1, prev_l = 1'b0, prev_sel = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic [DW-1:0] ed;
        logic          el;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < npk; p++) begin
                int len;
                len = (first16 && s == 1 && p == 0) ? 16 : int'($urandom_range(1, maxlen));
                for (int b = 0; b < len; b++) begin
                    ed = $urandom;
                    el = (b == len - 1);
                    if (s == 0) begin d0.push_back(ed); l0.push_back(el); q0d.push_back(ed); q0l.push_back(el); end
                    else        begin d1.push_back(ed); l1.push_back(el); q1d.push_back(ed); q1l.push_back(el); end
                end
            end
        end
        while (pkts < stop_pkts && cyc < 5000) begin
            cyc++;
            if (!v0 && idx0 < d0.size() && int'($urandom_range(0, 99)) < pv) v0 = 1;
            if (!v1 && idx1 < d1.size() && int'($urandom_range(0, 99)) < pv) v1 = 1;
            s0_v = v0; s0_d = v0 ? d0[idx0] : '0; s0_l = v0 ? l0[idx0] : 1'b0;
            s1_v = v1; s1_d = v1 ? d1[idx1] : '0; s1_l = v1 ? l1[idx1] : 1'b0;
            m_r  = (int'($urandom_range(0, 99)) < pr);
            #1;
            chk("rdy_exclusive", 64'(s0_r & s1_r), 64'(0));
            if (prev_v && !prev_r)
                chk("m_hold", 64'({m_v, m_l, sel, m_d}), 64'({1'b1, prev_l, prev_sel, prev_d}));
            hs0 = v0 && s0_r;
            hs1 = v1 && s1_r;
            if (m_v && m_r) begin
                if (sel == 1'b0) begin
                    chk("beat_src0_expected", 64'(q0d.size() > 0), 64'(1));
                    if (q0d.size() > 0) begin ed = q0d.pop_front(); el = q0l.pop_front(); end
                end else begin
                    chk("beat_src1_expected", 64'(q1d.size() > 0), 64'(1));
                    if (q1d.size() > 0) begin ed = q1d.pop_front(); el = q1l.pop_front(); end
                end
                chk("m_beat", 64'({m_l, m_d}), 64'({el, ed}));
                if (!in_pkt) begin
                    if (alt) chk("sel_alternate", 64'(sel), 64'(next_alt));
                    next_alt = !sel;
                    cur      = sel;
                    in_pkt   = 1;
                end else begin
                    chk("no_interleave", 64'(sel), 64'(cur));
                end
                if (m_l) begin
                    in_pkt = 0;
                    pkts++;
                    exp_cnt++;
                end
            end
            prev_v = m_v; prev_r = m_r; prev_l = m_l; prev_sel = sel; prev_d = m_d;
            @(posedge clk); #1;
            if (hs0) begin idx0++; v0 = 0; end
            if (hs1) begin idx1++; v1 = 0; end
            chk("pkt_count", 64'(cnt), 64'(exp_cnt[15:0]));
            chk("pkt_count_w4", 64'(cnt_w), 64'(exp_cnt[3:0]));
        end
        chk("packets_done", 64'(pkts), 64'(stop_pkts));
        if (stop_pkts == 2 * npk)
            chk("drained", 64'(q0d.size() + q1d.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        do_reset();

        // rst s0v s0d  s0l s1v s1d s1l mr | s0r s1r mv md  ml sel cnt
        tbl.push_back(mk(1, 0, 0,    0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 0,    0, 1,  1, 0, 1, 'h10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h11, 0, 0, 0,    0, 1,  1, 0, 1, 'h11, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h12, 0, 0, 0,    0, 1,  1, 0, 1, 'h12, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h13, 1, 0, 0,    0, 1,  1, 0, 1, 'h13, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 0, 1));
        tbl.push_back(mk(1, 1, 'h20, 0, 1, 'h30, 0, 1,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h20, 0, 1, 'h30, 0, 1,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h20, 0, 1, 'h30, 0, 1,  1, 0, 1, 'h20, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h21, 0, 1, 'h30, 0, 1,  1, 0, 1, 'h21, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h22, 1, 1, 'h30, 0, 1,  1, 0, 1, 'h22, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h30, 0, 1,  0, 0, 0, 0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h30, 0, 1,  0, 1, 1, 'h30, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h31, 0, 1,  0, 1, 1, 'h31, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h32, 1, 1,  0, 1, 1, 'h32, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 0, 2));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h40, 0, 1,  0, 0, 0, 0,    0, 0, 2));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h40, 0, 1,  0, 1, 1, 'h40, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h41, 0, 0,  0, 0, 1, 'h40, 0, 1, 2));
        tbl.push_back(mk(1, 1, 'h50, 1, 1, 'h41, 1, 0,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h50, 1, 1, 'h41, 1, 1,  0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 'h50, 1, 1, 'h41, 1, 1,  1, 0, 1, 'h50, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h41, 1, 1,  0, 0, 0, 0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 0,    0, 1, 'h41, 1, 1,  0, 1, 1, 'h41, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 0, 1, 'h41, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 1,  0, 0, 0, 0,    0, 0, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            set_in(int'(v.rst), int'(v.s0v), int'(v.s0d), int'(v.s0l),
                   int'(v.s1v), int'(v.s1d), int'(v.s1l), int'(v.mr));
            #1;
            chk($sformatf("row%0d_rdy", i), 64'({s0_r, s1_r}), 64'({v.e_s0r, v.e_s1r}));
            chk($sformatf("row%0d_rdy_w4", i), 64'({s0_r_w, s1_r_w}), 64'({v.e_s0r, v.e_s1r}));
            @(posedge clk); #1;
            chk($sformatf("row%0d_mvalid", i), 64'(m_v), 64'(v.e_mv));
            chk($sformatf("row%0d_mvalid_w4", i), 64'(m_v_w), 64'(v.e_mv));
            if (v.e_mv) begin
                chk($sformatf("row%0d_beat", i), 64'({m_l, sel, m_d}), 64'({v.e_ml, v.e_sel, v.e_md}));
                chk($sformatf("row%0d_beat_w4", i), 64'({m_l_w, sel_w, m_d_w}), 64'({v.e_ml, v.e_sel, v.e_md}));
            end
            chk($sformatf("row%0d_cnt", i), 64'(cnt), 64'(v.e_cnt));
            chk($sformatf("row%0d_cnt_w4", i), 64'(cnt_w), 64'(v.e_cnt[3:0]));
        end

        // S0 stalls mid-packet while S1 waits: grant must stay on S0.
        do_reset();
        set_in(0, 1, 'h60, 0, 1, 'h70, 0, 1);
        #1; chk("stall_idle_rdy", 64'({s0_r, s1_r}), 64'(2'b00));
        @(posedge clk); #1;
        #1; chk("stall_grant0_rdy", 64'({s0_r, s1_r}), 64'(2'b10));
        @(posedge clk); #1;
        chk("stall_first_beat", 64'({m_v, sel, m_d}), 64'({1'b1, 1'b0, 32'h60}));
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 0, 1, 'h70, 0, 1);
            #1; chk("stall_hold_rdy", 64'({s0_r, s1_r}), 64'(2'b10));
            @(posedge clk); #1;
            chk("stall_m_empty", 64'(m_v), 64'(0));
        end
        set_in(0, 1, 'h61, 1, 1, 'h70, 0, 1);
        #1; chk("stall_last_rdy", 64'({s0_r, s1_r}), 64'(2'b10));
        @(posedge clk); #1;
        chk("stall_last_beat", 64'({m_v, m_l, sel, m_d}), 64'({1'b1, 1'b1, 1'b0, 32'h61}));
        set_in(0, 0, 0, 0, 1, 'h70, 0, 1);
        #1; chk("stall_bubble_rdy", 64'({s0_r, s1_r}), 64'(2'b00));
        @(posedge clk); #1;
        chk("stall_cnt", 64'(cnt), 64'(1));
        #1; chk("stall_grant1_rdy", 64'({s0_r, s1_r}), 64'(2'b01));
        @(posedge clk); #1;
        chk("stall_s1_beat", 64'({m_v, sel, m_d}), 64'({1'b1, 1'b1, 32'h70}));

        // Both sources always valid: strict alternation, 17 packets wraps the 4-bit counter to 1.
        do_reset();
        run_traffic(10, 4, 100, 100, 1'b0, 17, 1'b1);
        chk("alt_cnt17", 64'(cnt), 64'(17));
        chk("wrap_cnt_w4", 64'(cnt_w), 64'(1));

        // Random valid gaps and 50% downstream backpressure, S1 opens with a 16-beat packet.
        do_reset();
        run_traffic(6, 16, 60, 50, 1'b1, 12, 1'b0);
        do_reset();
        run_traffic(8, 6, 30, 80, 1'b0, 16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
